secuenciador_bias: RTL

Sequencer for the GARO bias measurement path. It steps a shared oscillator-select mux across `N_OSC` oscillators, runs one bias measurement per oscillator on the single bias meter, and returns each count tagged with its oscillator index over a valid/ready stream. It sits between the host/UART command layer and the bias meter plus oscillator mux, and is the only block that drives the meter's enable and resolution.

---
 rtl/secuenciador_bias_if.sv | 43 ++++
 rtl/secuenciador_bias.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/secuenciador_bias_if.sv
// secuenciador_bias_if
// Bus between the bias sequencer and its neighbours: the oscillator mux select,
// the bias meter control/result signals and the tagged result stream towards
// the host command layer. The sequencer uses the master modport; the meter,
// mux and result consumer side uses the slave modport.
interface secuenciador_bias_if #(
    parameter int SEL_WIDTH = 3,
    parameter int OUT_WIDTH = 32
);
    logic [SEL_WIDTH-1:0] sel;
    logic                 med_enable;
    logic [4:0]           med_resol;
    logic                 med_lock;
    logic [OUT_WIDTH-1:0] med_out;
    logic [OUT_WIDTH-1:0] dout;
    logic [SEL_WIDTH-1:0] dout_osc;
    logic                 dout_valid;
    logic                 dout_ready;

    modport master (
        output sel,
        output med_enable,
        output med_resol,
        input  med_lock,
        input  med_out,
        output dout,
        output dout_osc,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  sel,
        input  med_enable,
        input  med_resol,
        output med_lock,
        output med_out,
        input  dout,
        input  dout_osc,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/secuenciador_bias.sv
// secuenciador_bias
// Sweeps the shared oscillator mux over N_OSC oscillators, runs one bias
// measurement per oscillator on the single bias meter and streams each count
// out tagged with its oscillator index. All outputs are registered.
// Optional feature: define SECUENCIADOR_BIAS_SETTLE_EN to hold SETTLE for
// SETTLE cycles after every select change; otherwise SETTLE lasts one cycle.
module secuenciador_bias #(
    parameter int N_OSC     = 8,
    parameter int SEL_WIDTH = 3,
    parameter int OUT_WIDTH = 32,
    parameter int SETTLE    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [4:0]                 resol,
    secuenciador_bias_if.master        bus,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_EMIT,
        S_CLEAR
    } state_t;

    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(N_OSC - 1);

    state_t               r_state;
    state_t               w_nextState;
    logic                 w_settleDone;

    logic [SEL_WIDTH-1:0] r_sel;
    logic                 r_medEnable;
    logic [4:0]           r_medResol;
    logic [OUT_WIDTH-1:0] r_dout;
    logic [SEL_WIDTH-1:0] r_doutOsc;
    logic                 r_doutValid;
    logic                 r_busy;
    logic                 r_done;

`ifdef SECUENCIADOR_BIAS_SETTLE_EN
    localparam int SETTLE_CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SETTLE_CW-1:0] SETTLE_LAST = SETTLE_CW'(SETTLE - 1);

    logic [SETTLE_CW-1:0] r_settleCnt;

    // Settle timer: counts cycles spent in SETTLE, restarting on every entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_settleCnt <= '0;
        end else if (r_state == S_SETTLE && w_nextState == S_SETTLE) begin
            r_settleCnt <= r_settleCnt + 1'b1;
        end else begin
            r_settleCnt <= '0;
        end
    end

    assign w_settleDone = (r_settleCnt == SETTLE_LAST);
`else
    // Without the settle timer SETTLE always lasts one cycle, whatever SETTLE says.
    assign w_settleDone = 1'b1 | (SETTLE != 0);
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; abort wins over everything, including a same-cycle start.
    always_comb begin
        w_nextState = r_state;
        if (abort) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_nextState = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_settleDone) begin
                        w_nextState = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (bus.med_lock) begin
                        w_nextState = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (bus.dout_ready) begin
                        w_nextState = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_sel == LAST_SEL) begin
                        w_nextState = S_IDLE;
                    end else begin
                        w_nextState = S_SETTLE;
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase
        end
    end

    // Registered outputs, decoded from the state being entered so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_medEnable <= 1'b0;
            r_doutValid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_medEnable <= (w_nextState == S_MEASURE) || (w_nextState == S_EMIT);
            r_doutValid <= (w_nextState == S_EMIT);
            r_busy      <= (w_nextState != S_IDLE);
            r_done      <= (w_nextState == S_CLEAR) && (r_sel == LAST_SEL);
        end
    end

    // Sweep bookkeeping: resolution latch and mux select, which only ever counts up.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel      <= '0;
            r_medResol <= '0;
        end else if (r_state == S_IDLE && w_nextState == S_SETTLE) begin
            r_sel      <= '0;
            r_medResol <= resol;
        end else if (r_state == S_CLEAR && w_nextState == S_SETTLE) begin
            r_sel      <= r_sel + 1'b1;
        end
    end

    // Result capture on the first locked cycle; held untouched through EMIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dout    <= '0;
            r_doutOsc <= '0;
        end else if (r_state == S_MEASURE && w_nextState == S_EMIT) begin
            r_dout    <= bus.med_out;
            r_doutOsc <= r_sel;
        end
    end

    assign bus.sel        = r_sel;
    assign bus.med_enable = r_medEnable;
    assign bus.med_resol  = r_medResol;
    assign bus.dout       = r_dout;
    assign bus.dout_osc   = r_doutOsc;
    assign bus.dout_valid = r_doutValid;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
